// File: rtl/string_batch_ctrl_if.sv
// Byte-stream input and matched-character output streams of string_batch_ctrl.
// The controller connects through the slave modport; the feeding/draining side uses master.
interface string_batch_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] chr_data;
    logic       chr_valid;
    logic       chr_ready;
    logic       chr_last;

    modport master (
        output in_data, in_valid, chr_ready,
        input  in_ready, chr_data, chr_valid, chr_last
    );

    modport slave (
        input  in_data, in_valid, chr_ready,
        output in_ready, chr_data, chr_valid, chr_last
    );
endinterface

// File: rtl/string_batch_ctrl.sv
// Batch sequencer for one string_process_match: latches a command, starts the matcher,
// meters the byte stream into it, waits for done under a timeout, reports the result
// and drains the matched string one character per handshake.
module string_batch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_STR_BYTES  = 55
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic [15:0]            cmd_num_bytes,
    input  logic [5:0]             cmd_str_bytes,
    input  logic [127:0]           cmd_target_hash,
    output logic                   cmd_busy,
    string_batch_ctrl_if.slave     strm,
    output logic                   res_valid,
    output logic                   res_match,
    output logic [15:0]            res_byte_pos,
    output logic                   res_timeout,
    output logic                   res_error,
    output logic                   proc_start,
    output logic [15:0]            proc_num_bytes,
    output logic [127:0]           proc_target_hash,
    output logic [15:0]            proc_str_len,
    output logic [7:0]             proc_data,
    output logic                   proc_data_valid,
    output logic                   proc_match_char_next,
    input  logic                   proc_done,
    input  logic                   proc_match,
    input  logic [15:0]            proc_byte_pos,
    input  logic [7:0]             proc_match_char
);

    typedef enum logic [2:0] {
        IDLE, CHECK, START, SETTLE, FEED, WAIT, REPORT, DRAIN
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [15:0]    num_bytes_q, num_bytes_d;
    logic [5:0]     str_bytes_q, str_bytes_d;
    logic [127:0]   target_q, target_d;
    logic [15:0]    fed_q, fed_d;
    logic [15:0]    timer_q, timer_d;
    logic [5:0]     char_q, char_d;
    logic [7:0]     proc_data_q, proc_data_d;
    logic           proc_data_valid_q, proc_data_valid_d;
    logic           proc_start_q, proc_start_d;
    logic           res_valid_q, res_valid_d;
    logic           cmd_busy_q, cmd_busy_d;
    logic           res_match_q, res_match_d;
    logic [15:0]    res_byte_pos_q, res_byte_pos_d;
    logic           res_timeout_q, res_timeout_d;
    logic           res_error_q, res_error_d;

    logic           in_ready_w;
    logic           in_xfer_w;
    logic           chr_last_w;
    logic [15:0]    bit_len_w;

    assign in_ready_w = (state_q == FEED) && (fed_q < num_bytes_q);
    assign in_xfer_w  = in_ready_w && strm.in_valid;
    assign chr_last_w = (state_q == DRAIN) && (char_q == str_bytes_q - 6'd1);
    assign bit_len_w  = {7'b0, str_bytes_q, 3'b000};

    assign strm.in_ready     = in_ready_w;
    assign strm.chr_valid    = (state_q == DRAIN);
    assign strm.chr_data     = (state_q == DRAIN) ? proc_match_char : '0;
    assign strm.chr_last     = chr_last_w;
    assign proc_match_char_next = (state_q == DRAIN) && strm.chr_ready;

    assign cmd_busy          = cmd_busy_q;
    assign res_valid         = res_valid_q;
    assign res_match         = res_match_q;
    assign res_byte_pos      = res_byte_pos_q;
    assign res_timeout       = res_timeout_q;
    assign res_error         = res_error_q;
    assign proc_start        = proc_start_q;
    assign proc_num_bytes    = num_bytes_q;
    assign proc_target_hash  = target_q;
    assign proc_str_len      = {bit_len_w[7:0], bit_len_w[15:8]};
    assign proc_data         = proc_data_q;
    assign proc_data_valid   = proc_data_valid_q;

    // Next-state and datapath updates; strobes are derived from the next state so they register cleanly.
    always_comb begin
        state_d           = state_q;
        num_bytes_d       = num_bytes_q;
        str_bytes_d       = str_bytes_q;
        target_d          = target_q;
        fed_d             = fed_q;
        timer_d           = timer_q;
        char_d            = char_q;
        proc_data_d       = proc_data_q;
        proc_data_valid_d = 1'b0;
        res_match_d       = res_match_q;
        res_byte_pos_d    = res_byte_pos_q;
        res_timeout_d     = res_timeout_q;
        res_error_d       = res_error_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    num_bytes_d    = cmd_num_bytes;
                    str_bytes_d    = cmd_str_bytes;
                    target_d       = cmd_target_hash;
                    res_match_d    = 1'b0;
                    res_byte_pos_d = '0;
                    res_timeout_d  = 1'b0;
                    res_error_d    = 1'b0;
                    state_d        = CHECK;
                end
            end
            CHECK: begin
                if (str_bytes_q == 6'd0 || 32'(str_bytes_q) > MAX_STR_BYTES) begin
                    res_error_d = 1'b1;
                    state_d     = REPORT;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                fed_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = FEED;
            end
            FEED: begin
                if (in_xfer_w) begin
                    proc_data_d       = strm.in_data;
                    proc_data_valid_d = 1'b1;
                    fed_d             = fed_q + 16'd1;
                end
                if (fed_q == num_bytes_q) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (proc_done) begin
                    res_match_d    = proc_match;
                    res_byte_pos_d = proc_byte_pos;
                    state_d        = REPORT;
                end else if (timer_q == TMO_LAST) begin
                    res_timeout_d = 1'b1;
                    res_match_d   = 1'b0;
                    state_d       = REPORT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            REPORT: begin
                if (res_match_q) begin
                    char_d  = '0;
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (strm.chr_ready) begin
                    char_d = char_q + 6'd1;
                    if (chr_last_w) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        proc_start_d = (state_d == START);
        res_valid_d  = (state_d == REPORT);
        cmd_busy_d   = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            num_bytes_q       <= '0;
            str_bytes_q       <= '0;
            target_q          <= '0;
            fed_q             <= '0;
            timer_q           <= '0;
            char_q            <= '0;
            proc_data_q       <= '0;
            proc_data_valid_q <= 1'b0;
            proc_start_q      <= 1'b0;
            res_valid_q       <= 1'b0;
            cmd_busy_q        <= 1'b0;
            res_match_q       <= 1'b0;
            res_byte_pos_q    <= '0;
            res_timeout_q     <= 1'b0;
            res_error_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            num_bytes_q       <= num_bytes_d;
            str_bytes_q       <= str_bytes_d;
            target_q          <= target_d;
            fed_q             <= fed_d;
            timer_q           <= timer_d;
            char_q            <= char_d;
            proc_data_q       <= proc_data_d;
            proc_data_valid_q <= proc_data_valid_d;
            proc_start_q      <= proc_start_d;
            res_valid_q       <= res_valid_d;
            cmd_busy_q        <= cmd_busy_d;
            res_match_q       <= res_match_d;
            res_byte_pos_q    <= res_byte_pos_d;
            res_timeout_q     <= res_timeout_d;
            res_error_q       <= res_error_d;
        end
    end

endmodule

// File: tb/tb_string_batch_ctrl.sv
// Directed bench for string_batch_ctrl: the matcher is stood in for by the test tasks
// (done/match/byte_pos) plus a character source indexed by proc_match_char_next.
module tb_string_batch_ctrl;

    localparam logic [127:0] HASH = 128'h0123456789abcdef_fedcba9876543210;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_start = 1'b0;
    logic [15:0]  cmd_num_bytes = '0;
    logic [5:0]   cmd_str_bytes = '0;
    logic [127:0] cmd_target_hash = '0;
    logic         cmd_busy;
    logic         res_valid, res_match, res_timeout, res_error;
    logic [15:0]  res_byte_pos;
    logic         proc_start, proc_data_valid, proc_match_char_next;
    logic [15:0]  proc_num_bytes, proc_str_len;
    logic [127:0] proc_target_hash;
    logic [7:0]   proc_data;
    logic         proc_done = 1'b0;
    logic         proc_match = 1'b0;
    logic [15:0]  proc_byte_pos = '0;
    logic [7:0]   proc_match_char;

    string_batch_ctrl_if sif ();

    string_batch_ctrl #(.TIMEOUT_CYCLES(16), .MAX_STR_BYTES(55)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_num_bytes(cmd_num_bytes), .cmd_str_bytes(cmd_str_bytes),
        .cmd_target_hash(cmd_target_hash), .cmd_busy(cmd_busy),
        .strm(sif),
        .res_valid(res_valid), .res_match(res_match), .res_byte_pos(res_byte_pos),
        .res_timeout(res_timeout), .res_error(res_error),
        .proc_start(proc_start), .proc_num_bytes(proc_num_bytes), .proc_target_hash(proc_target_hash),
        .proc_str_len(proc_str_len), .proc_data(proc_data), .proc_data_valid(proc_data_valid),
        .proc_match_char_next(proc_match_char_next),
        .proc_done(proc_done), .proc_match(proc_match), .proc_byte_pos(proc_byte_pos),
        .proc_match_char(proc_match_char)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Character source: k-th character after proc_start is 'A'+k.
    int chr_idx = 0;
    assign proc_match_char = 8'h41 + 8'(chr_idx);
    always @(posedge clk) begin
        if (proc_start) chr_idx <= 0;
        else if (proc_match_char_next) chr_idx <= chr_idx + 1;
    end

    // Monitor, sampling mid-cycle.
    int cyc = 0, start_cnt = 0, next_cnt = 0, last_cnt = 0, last_pos = -1;
    int start_cyc = 0, rv_cyc = 0;
    logic [7:0] byte_q[$];
    logic [7:0] chr_q[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (proc_start) begin start_cnt++; start_cyc = cyc; end
        if (proc_data_valid) byte_q.push_back(proc_data);
        if (res_valid) rv_cyc = cyc;
        if (sif.chr_valid && sif.chr_ready) begin
            if (sif.chr_last) begin last_cnt++; last_pos = chr_q.size(); end
            chr_q.push_back(sif.chr_data);
        end
        if (proc_match_char_next) next_cnt++;
    end

    task automatic issue_cmd(input logic [15:0] num, input logic [5:0] str, input logic [127:0] hash);
        @(posedge clk); #1;
        cmd_num_bytes = num; cmd_str_bytes = str; cmd_target_hash = hash; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic feed_bytes(input int n, input logic [7:0] base, input bit rnd);
        int i = 0;
        int cycles = 0;
        bit xfer;
        while (i < n && cycles < 1000) begin
            sif.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.in_data  = base + 8'(i);
            @(negedge clk);
            xfer = sif.in_valid && sif.in_ready;
            @(posedge clk); #1;
            if (xfer) i++;
            cycles++;
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (!cmd_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (cmd_busy !== 1'b0 || sif.in_ready !== 1'b0) begin miscompares++;
            $display("FAIL reset_ctrl: busy=%b in_ready=%b expected 0 0", cmd_busy, sif.in_ready); end
        vectors++; if ({res_valid, res_match, res_byte_pos, res_timeout, res_error} !== '0) begin miscompares++;
            $display("FAIL reset_res: got %h expected 0", {res_valid, res_match, res_byte_pos, res_timeout, res_error}); end
        vectors++; if ({proc_start, proc_data_valid, proc_match_char_next, proc_data, proc_num_bytes, proc_str_len, proc_target_hash} !== '0) begin miscompares++;
            $display("FAIL reset_proc: got %h expected 0", {proc_start, proc_data_valid, proc_match_char_next, proc_data, proc_num_bytes, proc_str_len, proc_target_hash}); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_match();
        int b0, c0, n0, l0, s0, bad;
        bit ok;
        sif.chr_ready = 1'b1;
        b0 = byte_q.size(); c0 = chr_q.size(); n0 = next_cnt; l0 = last_cnt; s0 = start_cnt;
        issue_cmd(16'd20, 6'd19, HASH);
        vectors++; if (cmd_busy !== 1'b1) begin miscompares++; $display("FAIL match_busy: got %b expected 1", cmd_busy); end
        vectors++; if (proc_str_len !== 16'h9800) begin miscompares++; $display("FAIL match_str_len: got %h expected 9800", proc_str_len); end
        vectors++; if (proc_num_bytes !== 16'd20 || proc_target_hash !== HASH) begin miscompares++;
            $display("FAIL match_cmd_regs: got %0d %h expected 20 %h", proc_num_bytes, proc_target_hash, HASH); end
        feed_bytes(20, 8'h10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        proc_match = 1'b1; proc_byte_pos = 16'h0005; proc_done = 1'b1;
        wait_res(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL match_res_timeout: got no res_valid expected one"); end
        vectors++; if ({res_match, res_byte_pos, res_timeout, res_error} !== {1'b1, 16'h0005, 1'b0, 1'b0}) begin miscompares++;
            $display("FAIL match_res: got m=%b pos=%h to=%b err=%b expected 1 0005 0 0", res_match, res_byte_pos, res_timeout, res_error); end
        @(posedge clk); #1;
        proc_done = 1'b0;
        wait_idle(ok);
        @(posedge clk); #1;
        vectors++; if (!ok) begin miscompares++; $display("FAIL match_idle: got busy expected idle"); end
        bad = 0;
        for (int i = 0; i < 20; i++) if (b0 + i >= byte_q.size() || byte_q[b0 + i] !== 8'h10 + 8'(i)) bad++;
        vectors++; if (byte_q.size() - b0 != 20 || bad != 0) begin miscompares++;
            $display("FAIL match_bytes: got %0d bytes %0d wrong expected 20 0", byte_q.size() - b0, bad); end
        bad = 0;
        for (int i = 0; i < 19; i++) if (c0 + i >= chr_q.size() || chr_q[c0 + i] !== 8'h41 + 8'(i)) bad++;
        vectors++; if (chr_q.size() - c0 != 19 || bad != 0) begin miscompares++;
            $display("FAIL match_chars: got %0d chars %0d wrong expected 19 0", chr_q.size() - c0, bad); end
        vectors++; if (last_cnt - l0 != 1 || last_pos != c0 + 18) begin miscompares++;
            $display("FAIL match_last: got cnt=%0d pos=%0d expected 1 %0d", last_cnt - l0, last_pos, c0 + 18); end
        vectors++; if (next_cnt - n0 != 19 || start_cnt - s0 != 1) begin miscompares++;
            $display("FAIL match_pulses: got next=%0d start=%0d expected 19 1", next_cnt - n0, start_cnt - s0); end
        vectors++; if (res_match !== 1'b1 || res_byte_pos !== 16'h0005) begin miscompares++;
            $display("FAIL match_held: got %b %h expected 1 0005", res_match, res_byte_pos); end
    endtask

    task automatic test_nomatch();
        int c0, n0;
        bit ok;
        c0 = chr_q.size(); n0 = next_cnt;
        issue_cmd(16'd20, 6'd19, HASH);
        feed_bytes(20, 8'h50, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        proc_match = 1'b0; proc_byte_pos = 16'h0007; proc_done = 1'b1;
        wait_res(ok);
        vectors++; if (!ok || res_match !== 1'b0 || res_timeout !== 1'b0) begin miscompares++;
            $display("FAIL nomatch_res: got ok=%b m=%b to=%b expected 1 0 0", ok, res_match, res_timeout); end
        @(negedge clk);
        vectors++; if (cmd_busy !== 1'b0) begin miscompares++; $display("FAIL nomatch_idle: got busy=%b expected 0", cmd_busy); end
        @(posedge clk); #1;
        proc_done = 1'b0;
        @(posedge clk); #1;
        vectors++; if (chr_q.size() != c0 || next_cnt != n0) begin miscompares++;
            $display("FAIL nomatch_chars: got %0d chars %0d next expected 0 0", chr_q.size() - c0, next_cnt - n0); end
    endtask

    task automatic test_error();
        logic [5:0] lens [2];
        int s0;
        bit ok, ok2;
        lens[0] = 6'd0; lens[1] = 6'd56;
        for (int t = 0; t < 2; t++) begin
            s0 = start_cnt;
            issue_cmd(16'd4, lens[t], HASH);
            wait_res(ok);
            vectors++; if (!ok || res_error !== 1'b1 || res_match !== 1'b0) begin miscompares++;
                $display("FAIL error_res_%0d: got ok=%b err=%b m=%b expected 1 1 0", lens[t], ok, res_error, res_match); end
            wait_idle(ok2);
            @(posedge clk); #1;
            vectors++; if (!ok2 || start_cnt != s0) begin miscompares++;
                $display("FAIL error_nostart_%0d: got idle=%b starts=%0d expected 1 0", lens[t], ok2, start_cnt - s0); end
        end
    endtask

    task automatic test_timeout();
        int c0;
        bit ok, seen;
        proc_done = 1'b0;
        issue_cmd(16'd0, 6'd4, HASH);
        wait_res(ok);
        vectors++; if (!ok || res_timeout !== 1'b1 || res_match !== 1'b0) begin miscompares++;
            $display("FAIL timeout_res: got ok=%b to=%b m=%b expected 1 1 0", ok, res_timeout, res_match); end
        @(posedge clk); #1;
        vectors++; if (rv_cyc - start_cyc != 19) begin miscompares++;
            $display("FAIL timeout_latency: got %0d expected 19", rv_cyc - start_cyc); end
        wait_idle(ok);
        // done raised in the last WAIT cycle must win over the timeout
        c0 = chr_q.size();
        sif.chr_ready = 1'b1;
        issue_cmd(16'd0, 6'd2, HASH);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (proc_start) begin seen = 1'b1; break; end
        end
        repeat (18) begin @(posedge clk); #1; end
        proc_done = 1'b1; proc_match = 1'b1; proc_byte_pos = 16'h0abc;
        wait_res(ok);
        vectors++; if (!seen || !ok || res_match !== 1'b1 || res_timeout !== 1'b0 || res_byte_pos !== 16'h0abc) begin miscompares++;
            $display("FAIL timeout_done_wins: got m=%b to=%b pos=%h expected 1 0 0abc", res_match, res_timeout, res_byte_pos); end
        @(posedge clk); #1;
        proc_done = 1'b0;
        wait_idle(ok);
        @(posedge clk); #1;
        vectors++; if (rv_cyc - start_cyc != 19 || chr_q.size() - c0 != 2) begin miscompares++;
            $display("FAIL timeout_done_edge: got lat=%0d chars=%0d expected 19 2", rv_cyc - start_cyc, chr_q.size() - c0); end
    endtask

    task automatic test_throttle();
        int b0, c0, n0, l0, bad;
        bit ok, done;
        b0 = byte_q.size(); c0 = chr_q.size(); n0 = next_cnt; l0 = last_cnt;
        sif.chr_ready = 1'b0;
        issue_cmd(16'd12, 6'd5, HASH);
        feed_bytes(12, 8'h80, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        proc_match = 1'b1; proc_byte_pos = 16'h0003; proc_done = 1'b1;
        wait_res(ok);
        @(posedge clk); #1;
        proc_done = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            sif.chr_ready = (k % 3 == 0);
            @(posedge clk); #1;
            if (!cmd_busy) begin done = 1'b1; break; end
        end
        sif.chr_ready = 1'b0;
        @(posedge clk); #1;
        vectors++; if (!ok || !done) begin miscompares++; $display("FAIL throttle_flow: got res=%b idle=%b expected 1 1", ok, done); end
        bad = 0;
        for (int i = 0; i < 12; i++) if (b0 + i >= byte_q.size() || byte_q[b0 + i] !== 8'h80 + 8'(i)) bad++;
        vectors++; if (byte_q.size() - b0 != 12 || bad != 0) begin miscompares++;
            $display("FAIL throttle_bytes: got %0d bytes %0d wrong expected 12 0", byte_q.size() - b0, bad); end
        bad = 0;
        for (int i = 0; i < 5; i++) if (c0 + i >= chr_q.size() || chr_q[c0 + i] !== 8'h41 + 8'(i)) bad++;
        vectors++; if (chr_q.size() - c0 != 5 || bad != 0 || next_cnt - n0 != 5) begin miscompares++;
            $display("FAIL throttle_chars: got %0d chars %0d wrong %0d next expected 5 0 5", chr_q.size() - c0, bad, next_cnt - n0); end
        vectors++; if (last_cnt - l0 != 1 || last_pos != c0 + 4) begin miscompares++;
            $display("FAIL throttle_last: got cnt=%0d pos=%0d expected 1 %0d", last_cnt - l0, last_pos, c0 + 4); end
    endtask

    task automatic test_reset_mid_and_stale();
        int b0, bad;
        bit ok, seen;
        issue_cmd(16'd20, 6'd19, HASH);
        feed_bytes(5, 8'h20, 1'b0);
        #2 reset = 1'b0;
        #1;
        vectors++; if (cmd_busy !== 1'b0 || sif.in_ready !== 1'b0 || sif.chr_valid !== 1'b0) begin miscompares++;
            $display("FAIL midreset_ctrl: got busy=%b rdy=%b chr=%b expected 0 0 0", cmd_busy, sif.in_ready, sif.chr_valid); end
        vectors++; if ({proc_start, proc_data_valid, proc_data, proc_num_bytes, proc_str_len, proc_target_hash} !== '0) begin miscompares++;
            $display("FAIL midreset_proc: got %h expected 0", {proc_start, proc_data_valid, proc_data, proc_num_bytes, proc_str_len, proc_target_hash}); end
        @(posedge clk); #1;
        reset = 1'b1;
        // stale done from a previous batch is high through START and SETTLE
        proc_done = 1'b1; proc_match = 1'b1; proc_byte_pos = 16'h0009;
        b0 = byte_q.size();
        issue_cmd(16'd4, 6'd3, HASH);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (proc_start) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        proc_done = 1'b0; proc_match = 1'b0;
        feed_bytes(4, 8'h30, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        proc_done = 1'b1;
        wait_res(ok);
        vectors++; if (!seen || !ok || res_match !== 1'b0 || res_timeout !== 1'b0) begin miscompares++;
            $display("FAIL stale_res: got start=%b ok=%b m=%b to=%b expected 1 1 0 0", seen, ok, res_match, res_timeout); end
        @(posedge clk); #1;
        proc_done = 1'b0;
        wait_idle(ok);
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 4; i++) if (b0 + i >= byte_q.size() || byte_q[b0 + i] !== 8'h30 + 8'(i)) bad++;
        vectors++; if (byte_q.size() - b0 != 4 || bad != 0) begin miscompares++;
            $display("FAIL stale_bytes: got %0d bytes %0d wrong expected 4 0", byte_q.size() - b0, bad); end
    endtask

    initial begin
        sif.in_valid = 1'b0; sif.in_data = '0; sif.chr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_match();
        test_nomatch();
        test_error();
        test_timeout();
        test_throttle();
        test_reset_mid_and_stale();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/string_batch_ctrl.md
# string_batch_ctrl

Sequencer for one `string_process_match` instance. It latches a batch command from the command parser and pulses `proc_start`, then meters `num_bytes` stream bytes into `proc_data` and waits for `proc_done` under a timeout. It reports the match result and, on a hit, drains the matched string out one character per handshake through `proc_match_char_next`. It sits between the command parser / byte stream and the matcher; the MD5 core side of the matcher is untouched.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65535: max cycles spent in WAIT before abort.
- `MAX_STR_BYTES`, 55: largest legal string length in bytes (448-bit message minus pad bit).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; low forces every register to its reset value immediately.
- `cmd_start` in 1: one-cycle batch request; ignored while `cmd_busy`=1.
- `cmd_num_bytes` in 16: bytes in batch (= hashes expected).
- `cmd_str_bytes` in 6: string length in bytes.
- `cmd_target_hash` in 128: target digest {a,b,c,d}.
- `cmd_busy` out 1: high from accepted `cmd_start` until return to IDLE.
- `in_data` in 8, `in_valid` in 1, `in_ready` out 1: byte stream, transfer on valid&&ready.
- `res_valid` out 1: one-cycle result strobe.
- `res_match` out 1, `res_byte_pos` out 16, `res_timeout` out 1, `res_error` out 1: result fields, held until next accepted `cmd_start`.
- `chr_data` out 8, `chr_valid` out 1, `chr_ready` in 1, `chr_last` out 1: matched-string output stream.
- `proc_start` out 1, `proc_num_bytes` out 16, `proc_target_hash` out 128, `proc_str_len` out 16, `proc_data` out 8, `proc_data_valid` out 1, `proc_match_char_next` out 1: drive matcher.
- `proc_done` in 1, `proc_match` in 1, `proc_byte_pos` in 16, `proc_match_char` in 8: matcher status.

## Operation
- States: IDLE, CHECK, START, SETTLE, FEED, WAIT, REPORT, DRAIN.
- IDLE: `cmd_start` latches num_bytes, str_bytes, target hash; clears res_* fields; goes to CHECK.
- CHECK: str_bytes==0 or >MAX_STR_BYTES → res_error=1, go to REPORT (matcher not started); else go to START.
- proc_str_len = byte-swap of bit length: bits = {str_bytes,3'b000} (16-bit); proc_str_len = {bits[7:0],bits[15:8]}. proc_num_bytes and proc_target_hash are driven from latched registers, stable from START through DRAIN.
- START: `proc_start`=1 for exactly one cycle, then SETTLE.
- SETTLE: one cycle; `proc_done` is not sampled here because it can be stale from the previous batch. Then FEED.
- FEED: `in_ready`=1 while fed_count < num_bytes. Each transfer registers `in_data` into `proc_data` with `proc_data_valid`=1 on the next cycle and increments the 16-bit fed_count. When fed_count==num_bytes (immediately if 0), go to WAIT.
- WAIT: 16-bit timer counts from 0. On `proc_done`=1: capture `proc_match`, `proc_byte_pos`, then REPORT. If timer==TIMEOUT_CYCLES-1 with no done: res_timeout=1, res_match=0, then REPORT. Done and last timer cycle coincident → done wins.
- REPORT: `res_valid`=1 one cycle. If res_match=1, go to DRAIN with char_count=0; else go to IDLE.
- DRAIN: `chr_valid`=1, `chr_data`=`proc_match_char` (combinational), `chr_last`=1 when char_count==str_bytes-1. A chr handshake pulses `proc_match_char_next` in the same cycle and increments char_count. The handshake on the last char returns to IDLE.
- Reset values: all outputs 0 (`proc_*` outputs, res_*, chr_*, `in_ready`, `cmd_busy`); state IDLE; counters 0.
- Reset asserted mid-batch: immediate return to IDLE. The matcher is not restarted until the next command.

## Timing
- `cmd_start` at edge N → CHECK N+1, START N+2 (proc_start high cycle N+2), SETTLE N+3, FEED N+4.
- `in_ready` is combinational from state and fed_count. `proc_data_valid` is 1-cycle latency from the input handshake. Back-to-back bytes are allowed, one per cycle.
- `proc_done` is sampled only in WAIT. REPORT is the cycle after done is seen; `res_valid` is high in that cycle.
- DRAIN: one char per cycle when `chr_ready` is held high. With `chr_ready`=0, `chr_data` is stable and `proc_match_char_next`=0.
- `cmd_busy`=1 from the cycle after the accepted `cmd_start` through the last DRAIN/REPORT cycle.

## Test plan
- Batch num_bytes=20, str_bytes=19, model raises done with match, byte_pos=0x0005 → proc_str_len=0x9800, 20 proc_data_valid pulses in byte order, res_valid with res_match=1, res_byte_pos=0x0005, 19 chars out with chr_last on the 19th.
- Same batch, no match → res_match=0, no chr_valid, back to IDLE in the cycle after REPORT.
- str_bytes=0 and str_bytes=56 → res_error=1, proc_start never asserted.
- Model never asserts done, TIMEOUT_CYCLES=16 → res_timeout=1 exactly 16 WAIT cycles after entry.
- `in_valid` toggled randomly and `chr_ready` throttled 1-in-3 → byte count and order preserved, one `proc_match_char_next` per accepted char.
- Reset low during FEED, and stale `proc_done`=1 during SETTLE → all outputs 0, IDLE; stale done ignored.
